fx2_fifo_reader: RTL and testbench

- Master-side reader for the FX2 slave FIFO interface in synchronous mode. It pulls 16-bit words from a host-to-device (OUT) endpoint FIFO into a local show-ahead buffer.
- The buffer presents words downstream with a valid/ready handshake.
- The block lives in the ifclk domain, beside the existing write path. The write path owns the bus only when this block reports idle; arbitration sits outside this block.

---
 rtl/fx2_fifo_reader.sv | 144 ++++++++++++++
 tb/tb_fx2_fifo_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_reader.sv
// FX2 slave-FIFO synchronous-mode reader: fetches 16-bit words from an OUT endpoint into a show-ahead buffer.
// Optional statistics counters are compiled in with `define FX2_RD_STATS_EN.
module fx2_fifo_reader #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_SETUP = 2,
  parameter logic [1:0]  EP_ADDR    = 2'b00
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enable_i,
  input  logic                       empty_i,
  input  logic [15:0]                fd_i,
  output logic [1:0]                 fifoaddr_o,
  output logic                       sloe_o,
  output logic                       slrd_o,
  output logic                       busy_o,
  output logic [15:0]                data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o
`ifdef FX2_RD_STATS_EN
  ,
  output logic [31:0]                word_count_o,
  output logic [15:0]                stall_count_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [2:0]    SETUP_LD = 3'(ADDR_SETUP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_OE,
    S_READ
  } state_t;

  state_t          r_state;
  logic [2:0]      r_setup_cnt;
  logic [1:0]      r_fifoaddr;
  logic            r_sloe;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            w_push;
  logic            w_pop;
  logic            w_full;

  assign w_full     = (r_level == FULL_LVL);
  // Read strobe is combinational so a word is issued the same cycle the FX2 reports data.
  assign w_push     = (r_state == S_READ) && !empty_i && !w_full && enable_i;
  assign w_pop      = (r_level != '0) && ready_i;

  assign slrd_o     = w_push;
  assign sloe_o     = r_sloe;
  assign fifoaddr_o = r_fifoaddr;
  assign busy_o     = (r_state != S_IDLE);
  assign valid_o    = (r_level != '0);
  assign level_o    = r_level;
  assign data_o     = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_setup_cnt <= '0;
      r_fifoaddr  <= '0;
      r_sloe      <= 1'b0;
    end else if (r_state != S_IDLE && !enable_i) begin
      r_state    <= S_IDLE;
      r_fifoaddr <= '0;
      r_sloe     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state     <= S_ADDR;
            r_setup_cnt <= SETUP_LD;
            r_fifoaddr  <= EP_ADDR;
          end
        end
        S_ADDR: begin
          if (r_setup_cnt == '0) begin
            r_state <= S_OE;
            r_sloe  <= 1'b1;
          end else begin
            r_setup_cnt <= r_setup_cnt - 3'd1;
          end
        end
        S_OE:    r_state <= S_READ;
        default: r_state <= S_READ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= fd_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef FX2_RD_STATS_EN
  logic [31:0] r_word_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_word_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push && r_word_count != '1) begin
        r_word_count <= r_word_count + 32'd1;
      end
      if (r_state == S_READ && !empty_i && w_full && r_stall_count != '1) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign word_count_o  = r_word_count;
  assign stall_count_o = r_stall_count;
`endif

endmodule

// File: tb/tb_fx2_fifo_reader.sv
// Directed bench for fx2_fifo_reader: FX2 OUT-FIFO model on one side, scripted consumer on the other.
module tb_fx2_fifo_reader;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        empty_i;
  logic [15:0] fd_i;
  logic [1:0]  fifoaddr_o;
  logic        sloe_o;
  logic        slrd_o;
  logic        busy_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] src [64];
  int unsigned n_avail = 0;
  int unsigned rd_idx  = 0;
  logic [15:0] pop_log [$];

  fx2_fifo_reader #(
    .DEPTH      (8),
    .ADDR_SETUP (2),
    .EP_ADDR    (2'b10)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enable_i   (enable_i),
    .empty_i    (empty_i),
    .fd_i       (fd_i),
    .fifoaddr_o (fifoaddr_o),
    .sloe_o     (sloe_o),
    .slrd_o     (slrd_o),
    .busy_o     (busy_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o)
  );

  always #5 clk_i = ~clk_i;

  // FX2 model: FD presents the next unread word; each strobed edge consumes one.
  assign empty_i = (rd_idx >= n_avail);
  assign fd_i    = src[rd_idx[5:0]];

  always @(posedge clk_i) begin
    if (slrd_o) rd_idx <= rd_idx + 1;
    if (reset_n_i && valid_o && ready_i) pop_log.push_back(data_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_words(input logic [15:0] base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      src[(n_avail + k) % 64] = base + 16'(k);
    end
    n_avail = n_avail + n;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_pops(input string tag, input int unsigned start, input logic [15:0] base,
                            input int unsigned n);
    check_eq({tag, "_count"}, pop_log.size() - start, n);
    for (int unsigned k = 0; k < n; k++) begin
      if (start + k < pop_log.size())
        check_eq(tag, 32'(pop_log[start + k]), 32'(base + 16'(k)));
    end
  endtask

  // After the enable edge: ADDR appears, sloe follows two cycles later, slrd the cycle after.
  task automatic check_bus_entry(input string tag);
    @(negedge clk_i);
    check_eq({tag, "_addr_busy"}, 32'(busy_o), 1);
    check_eq({tag, "_addr_fifoaddr"}, 32'(fifoaddr_o), 32'h2);
    check_eq({tag, "_addr_sloe0"}, 32'(sloe_o), 0);
    @(negedge clk_i);
    check_eq({tag, "_addr2_sloe0"}, 32'(sloe_o), 0);
    @(negedge clk_i);
    check_eq({tag, "_oe_sloe1"}, 32'(sloe_o), 1);
  endtask

  int unsigned start;
  int unsigned idx0;

  initial begin
    reset_n_i = 1'b0;
    enable_i  = 1'b1;
    ready_i   = 1'b1;
    cycles(3);
    check_eq("rst_fifoaddr", 32'(fifoaddr_o), 0);
    check_eq("rst_sloe", 32'(sloe_o), 0);
    check_eq("rst_slrd", 32'(slrd_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_level", 32'(level_o), 0);
    check_eq("rst_data", 32'(data_o), 0);

    // Reset release and bus entry; data appears during OE so first strobe is in READ.
    reset_n_i = 1'b1;
    check_bus_entry("boot");
    start = pop_log.size();
    add_words(16'h1001, 5);
    #1 check_eq("boot_oe_slrd0", 32'(slrd_o), 0);
    @(negedge clk_i);
    for (int unsigned k = 0; k < 5; k++) begin
      check_eq("burst_slrd1", 32'(slrd_o), 1);
      @(negedge clk_i);
    end
    check_eq("burst_slrd_end", 32'(slrd_o), 0);
    cycles(3);
    check_eq("burst_level0", 32'(level_o), 0);
    check_pops("burst_pop", start, 16'h1001, 5);

    // Backpressure: only DEPTH words fetched, full blocks the strobe even while popping.
    ready_i = 1'b0;
    idx0 = rd_idx;
    start = pop_log.size();
    add_words(16'h2001, 12);
    cycles(12);
    check_eq("bp_level8", 32'(level_o), 8);
    check_eq("bp_slrd0", 32'(slrd_o), 0);
    check_eq("bp_taken8", rd_idx - idx0, 8);
    check_eq("bp_head", 32'(data_o), 32'h2001);
    ready_i = 1'b1;
    #1 check_eq("bp_full_pop_slrd0", 32'(slrd_o), 0);
    cycles(20);
    check_eq("bp_level0", 32'(level_o), 0);
    check_eq("bp_taken12", rd_idx - idx0, 12);
    check_pops("bp_pop", start, 16'h2001, 12);

    // Simultaneous push and pop at level 3.
    ready_i = 1'b0;
    start = pop_log.size();
    add_words(16'h3001, 3);
    cycles(6);
    check_eq("pp_level3_pre", 32'(level_o), 3);
    add_words(16'h3004, 2);
    ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("pp_level3_a", 32'(level_o), 3);
    @(negedge clk_i);
    check_eq("pp_level3_b", 32'(level_o), 3);
    cycles(6);
    check_pops("pp_pop", start, 16'h3001, 5);

    // Enable drop after two of six words.
    ready_i = 1'b0;
    idx0 = rd_idx;
    start = pop_log.size();
    add_words(16'h4001, 6);
    cycles(2);
    check_eq("drop_taken2", rd_idx - idx0, 2);
    enable_i = 1'b0;
    #1 check_eq("drop_slrd0", 32'(slrd_o), 0);
    @(negedge clk_i);
    check_eq("drop_busy0", 32'(busy_o), 0);
    check_eq("drop_sloe0", 32'(sloe_o), 0);
    check_eq("drop_fifoaddr0", 32'(fifoaddr_o), 0);
    check_eq("drop_level2", 32'(level_o), 2);
    ready_i = 1'b1;
    cycles(4);
    check_eq("drop_drained", 32'(level_o), 0);
    check_eq("drop_idle_taken2", rd_idx - idx0, 2);
    enable_i = 1'b1;
    check_bus_entry("reen");
    check_eq("reen_oe_slrd0", 32'(slrd_o), 0);
    @(negedge clk_i);
    check_eq("reen_read_slrd1", 32'(slrd_o), 1);
    cycles(10);
    check_eq("reen_taken6", rd_idx - idx0, 6);
    check_pops("drop_pop", start, 16'h4001, 6);

    // Asynchronous reset with five words buffered.
    ready_i = 1'b0;
    add_words(16'h5001, 5);
    cycles(8);
    check_eq("ar_level5", 32'(level_o), 5);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("ar_level0", 32'(level_o), 0);
    check_eq("ar_valid0", 32'(valid_o), 0);
    check_eq("ar_busy0", 32'(busy_o), 0);
    check_eq("ar_sloe0", 32'(sloe_o), 0);
    check_eq("ar_data0", 32'(data_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
